// File: rtl/multicycle_fsm.sv
// rtl/multicycle_fsm.sv - multicycle RV32I-subset control FSM (lw/sw/R/I/beq/jal)
// Optional mul/div wait states are enabled by defining MULDIV_WAIT_EN.
module multicycle_fsm #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] state_o,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_MDWAIT   = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 16) begin : g_bad_cycles
    $error("MULDIV_CYCLES out of range 2..16");
  end

  state_t     state, next_state;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       ir_write_raw, reg_write_raw, mem_write_raw;
  logic       illegal_q;

`ifdef MULDIV_WAIT_EN
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);
  logic [3:0] md_count;
  logic       is_muldiv;

  assign is_muldiv = (funct7 == 7'b0000001 && funct3 == 3'b000) || (funct3 == 3'b100);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      md_count <= 4'd0;
    else if (state == S_EXECR)
      md_count <= MD_LOAD;
    else if (state == S_MDWAIT && md_count != 4'd0)
      md_count <= md_count - 4'd1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state    = S_FETCH;
    alu_op        = 2'b00;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = 1'b1;
        next_state   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
`ifdef MULDIV_WAIT_EN
        next_state = is_muldiv ? S_MDWAIT : S_ALUWB;
`else
        next_state = S_ALUWB;
`endif
      end
      S_MDWAIT: begin
        // Keeps EXECR's operand selects so a slow ALU sees stable inputs.
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
`ifdef MULDIV_WAIT_EN
        next_state = (md_count == 4'd0) ? S_ALUWB : S_MDWAIT;
`endif
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_op     = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 4'b0000;
    case (alu_op)
      2'b01: ALUControl = 4'b0001;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (op == OP_R && funct7 == 7'b0000001)      ALUControl = 4'b1001;
            else if (op == OP_R && funct7 == 7'b0100000) ALUControl = 4'b0001;
            else                                         ALUControl = 4'b0000;
          end
          3'b010: ALUControl = 4'b0101;
          3'b110: ALUControl = 4'b0011;
          3'b111: ALUControl = 4'b0010;
          3'b100: ALUControl = 4'b0100;
          3'b101: ALUControl = (funct7 == 7'b0100000) ? 4'b0110 : 4'b0111;
          3'b001: ALUControl = 4'b1000;
          default: ALUControl = 4'b0000;
        endcase
      end
      default: ALUControl = 4'b0000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write strobes are gated by reset so an abort never commits a partial write.
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
  assign IRWrite  = ir_write_raw & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign state_o  = state;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_fsm.sv
// tb/tb_multicycle_fsm.sv - directed self-checking bench for multicycle_fsm
module tb_multicycle_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl, state_o;

  int n_cmp = 0;
  int n_err = 0;
  int ncyc;

  logic [3:0] tr_state [0:31];
  logic [3:0] tr_aluc  [0:31];
  logic [1:0] tr_imm   [0:31];
  logic [1:0] tr_rs    [0:31];
  logic       tr_adr   [0:31];
  logic       tr_rw    [0:31];
  logic       tr_mw    [0:31];
  logic       tr_irw   [0:31];
  logic       tr_pcw   [0:31];

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  multicycle_fsm #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .state_o(state_o), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge while in FETCH; records every cycle until the next FETCH.
  task automatic run_instr(input logic [6:0] op_v, input logic [2:0] f3_v,
                           input logic [6:0] f7_v, input logic zero_v);
    op = op_v; funct3 = f3_v; funct7 = f7_v; Zero = zero_v;
    ncyc = 0;
    do begin
      tr_state[ncyc] = state_o;  tr_aluc[ncyc] = ALUControl; tr_imm[ncyc] = ImmSrc;
      tr_rs[ncyc]    = ResultSrc; tr_adr[ncyc] = AdrSrc;     tr_rw[ncyc]  = RegWrite;
      tr_mw[ncyc]    = MemWrite;  tr_irw[ncyc] = IRWrite;    tr_pcw[ncyc] = PCWrite;
      ncyc++;
      @(negedge clk);
    end while (state_o != 4'd0 && ncyc < 32);
  endtask

  task automatic alu_case(input string tag, input logic [6:0] op_v, input logic [2:0] f3_v,
                          input logic [6:0] f7_v, input logic [3:0] expv);
    run_instr(op_v, f3_v, f7_v, 1'b0);
    check(tag, tr_aluc[2], expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int irw_cnt, rw_bad, mw_any, bad, k;
    reset = 1'b1; op = OP_R; funct3 = 3'b000; funct7 = 7'b0000000; Zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_o, 4'd0);
    check("rst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
    check("rst_illegal", Illegal, 1'b0);
    reset = 1'b0;
    #1;

    // R-type add: 0,1,6,8
    run_instr(OP_R, 3'b000, 7'b0000000, 1'b0);
    check("add_cycles", ncyc, 4);
    check("add_states", {tr_state[0], tr_state[1], tr_state[2], tr_state[3]}, 16'h0168);
    irw_cnt = 0; rw_bad = 0;
    for (int i = 0; i < 4; i++) begin
      irw_cnt += int'(tr_irw[i]);
      if (tr_rw[i] !== (i == 3)) rw_bad++;
    end
    check("add_irwrite_pulses", irw_cnt, 1);
    check("add_regwrite_only_aluwb", rw_bad, 0);
    check("add_aluc", tr_aluc[2], 4'b0000);

    // lw: 0,1,2,3,4
    run_instr(OP_LW, 3'b010, 7'b0000000, 1'b0);
    check("lw_cycles", ncyc, 5);
    check("lw_states", {tr_state[0], tr_state[1], tr_state[2], tr_state[3], tr_state[4]}, 20'h01234);
    check("lw_adrsrc_memread", tr_adr[3], 1'b1);
    check("lw_memwb", {tr_rs[4], tr_rw[4]}, 3'b011);
    mw_any = 0;
    for (int i = 0; i < 5; i++) mw_any += int'(tr_mw[i]);
    check("lw_memwrite_never", mw_any, 0);

    // sw: 0,1,2,5
    run_instr(OP_SW, 3'b010, 7'b0000000, 1'b0);
    check("sw_cycles", ncyc, 4);
    check("sw_state3", tr_state[3], 4'd5);
    check("sw_memwrite", {tr_mw[3], tr_adr[3]}, 2'b11);
    check("sw_immsrc", tr_imm[2], 2'b01);

    // beq taken / not taken
    run_instr(OP_BEQ, 3'b000, 7'b0000000, 1'b1);
    check("beq1_cycles", ncyc, 3);
    check("beq1_state", tr_state[2], 4'd9);
    check("beq1_pcwrite", tr_pcw[2], 1'b1);
    check("beq1_imm_aluc", {tr_imm[2], tr_aluc[2]}, 6'b10_0001);
    run_instr(OP_BEQ, 3'b000, 7'b0000000, 1'b0);
    check("beq0_pcwrite", tr_pcw[2], 1'b0);
    check("beq0_imm_aluc", {tr_imm[2], tr_aluc[2]}, 6'b10_0001);

    // jal: 0,1,10,8
    run_instr(OP_JAL, 3'b000, 7'b0000000, 1'b0);
    check("jal_cycles", ncyc, 4);
    check("jal_states", {tr_state[0], tr_state[1], tr_state[2], tr_state[3]}, 16'h01A8);
    check("jal_pcwrite_imm", {tr_pcw[2], tr_imm[2], tr_rw[3]}, 4'b1111);

    // ALU decode
    run_instr(OP_I, 3'b010, 7'b0000000, 1'b0);
    check("slti_state", tr_state[2], 4'd7);
    check("slti_aluc", tr_aluc[2], 4'b0101);
    check("slti_cycles", ncyc, 4);
    alu_case("addi_f7hi_aluc", OP_I, 3'b000, 7'b0100000, 4'b0000);
    alu_case("addi_f7one_aluc", OP_I, 3'b000, 7'b0000001, 4'b0000);
    alu_case("sub_aluc", OP_R, 3'b000, 7'b0100000, 4'b0001);
    alu_case("sra_aluc", OP_R, 3'b101, 7'b0100000, 4'b0110);
    alu_case("srl_aluc", OP_R, 3'b101, 7'b0000000, 4'b0111);
    alu_case("or_aluc", OP_R, 3'b110, 7'b0000000, 4'b0011);
    alu_case("and_aluc", OP_R, 3'b111, 7'b0000000, 4'b0010);
    alu_case("sll_aluc", OP_R, 3'b001, 7'b0000000, 4'b1000);
    alu_case("div_aluc", OP_R, 3'b100, 7'b0000001, 4'b0100);
`ifdef MULDIV_WAIT_EN
    check("div_cycles", ncyc, 7);
`else
    check("div_cycles", ncyc, 4);
`endif

    // mul
    run_instr(OP_R, 3'b000, 7'b0000001, 1'b0);
`ifdef MULDIV_WAIT_EN
    check("mul_cycles", ncyc, 7);
    check("mul_states", {tr_state[2], tr_state[3], tr_state[4], tr_state[5], tr_state[6]}, 20'h6BBB8);
    check("mul_aluc_hold", {tr_aluc[2], tr_aluc[3], tr_aluc[4], tr_aluc[5]}, 16'h9999);
`else
    check("mul_cycles", ncyc, 4);
    check("mul_states", {tr_state[2], tr_state[3]}, 8'h68);
    check("mul_aluc", tr_aluc[2], 4'b1001);
`endif

    // Reset during MEMWRITE
    op = OP_SW; funct3 = 3'b010; funct7 = 7'b0000000;
    k = 0;
    while (state_o != 4'd5 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("mwr_reach", state_o, 4'd5);
    check("mwr_memwrite_pre", MemWrite, 1'b1);
    reset = 1'b1;
    #1;
    check("mwr_memwrite_reset", MemWrite, 1'b0);
    @(posedge clk);
    #1;
    check("mwr_state_after_edge", state_o, 4'd0);
    check("mwr_strobes_in_reset", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Illegal opcode
    op = 7'b1111111; funct3 = 3'b000; funct7 = 7'b0000000;
    check("ill_fetch", state_o, 4'd0);
    @(negedge clk);
    check("ill_decode", state_o, 4'd1);
    @(negedge clk);
    check("ill_state", state_o, 4'd12);
    check("ill_flag", Illegal, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (state_o !== 4'd12 || Illegal !== 1'b1) bad++;
      if ({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl} !== 17'd0) bad++;
      @(negedge clk);
    end
    check("ill_hold_20", bad, 0);
    reset = 1'b1;
    #1;
    check("ill_clear", Illegal, 1'b0);
    check("ill_reset_state", state_o, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
